// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the FSM and branch-kind encodings plus the label table's power-on contents.
package pc_sequencer_pkg;

    localparam int PC_W  = 16;
    localparam int NLBL  = 16;
    localparam int LBL_W = $clog2(NLBL);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_BRANCH,
        ST_HALTED
    } seq_state_e;

    typedef enum logic [1:0] {
        BR_ABS   = 2'b00,
        BR_LABEL = 2'b01,
        BR_COND  = 2'b10,
        BR_RSVD  = 2'b11
    } br_kind_e;

    localparam logic [15:0] LBL_DEFAULT [NLBL] = '{
        16'd10, 16'd22, 16'd102, 16'd152, 16'd196, 16'd212, 16'd8,  16'd39,
        16'd18, 16'd46, 16'd83,  16'd60,  16'd0,   16'd0,   16'd0,  16'd0
    };
    localparam logic [NLBL-1:0] LBL_DEFAULT_VALID = 16'h0FFF;

    // Lookups tolerate tables deeper than the default list; extra entries start invalid.
    function automatic logic [15:0] lbl_default(input int idx);
        lbl_default = '0;
        for (int k = 0; k < NLBL; k++)
            if (k == idx) lbl_default = LBL_DEFAULT[k];
    endfunction

    function automatic logic lbl_default_valid(input int idx);
        lbl_default_valid = 1'b0;
        for (int k = 0; k < NLBL; k++)
            if (k == idx) lbl_default_valid = LBL_DEFAULT_VALID[k];
    endfunction

endpackage

// File: rtl/pc_sequencer_label.sv
// Jump-label register file: one write port, one combinational read port.
// Each entry carries a valid bit; reset restores the default target list.
module label_table
    import pc_sequencer_pkg::*;
#(
    parameter int DW = 16,
    parameter int N  = 16,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    output logic          rvalid
);

    logic [DW-1:0] mem [N];
    logic [N-1:0]  vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= DW'(lbl_default(i));
                vld[i] <= lbl_default_valid(i);
            end
        end else if (we) begin
            mem[waddr] <= wdata;
            vld[waddr] <= 1'b1;
        end
    end

    // Reading the registers directly means a same-cycle write is seen only next cycle.
    assign rdata  = mem[raddr];
    assign rvalid = vld[raddr];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch addresses with stall, halt and
// absolute/label/conditional branches that cost one bubble cycle when taken.
module pc_sequencer #(
    parameter int              PC_W    = pc_sequencer_pkg::PC_W,
    parameter int              NLBL    = pc_sequencer_pkg::NLBL,
    parameter logic [PC_W-1:0] RST_VEC = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    halt,
    input  logic                    stall,
    input  logic                    lbl_we,
    input  logic [$clog2(NLBL)-1:0] lbl_waddr,
    input  logic [PC_W-1:0]         lbl_wdata,
    input  logic                    br_valid,
    output logic                    br_ready,
    input  logic [1:0]              br_kind,
    input  logic [PC_W-1:0]         br_target,
    input  logic [$clog2(NLBL)-1:0] br_label,
    input  logic                    br_cond,
    output logic [PC_W-1:0]         pc,
    output logic                    pc_valid,
    output logic                    busy,
    output logic                    err
);
    import pc_sequencer_pkg::*;

    seq_state_e      state, state_n;
    br_kind_e        kind;
    logic [PC_W-1:0] pc_n, pc_inc, tgt, lbl_rdata;
    logic            lbl_rvalid, take, bad, accept, err_n;

    label_table #(
        .DW (PC_W),
        .N  (NLBL)
    ) u_label_table (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (lbl_we),
        .waddr  (lbl_waddr),
        .wdata  (lbl_wdata),
        .raddr  (br_label),
        .rdata  (lbl_rdata),
        .rvalid (lbl_rvalid)
    );

    assign kind     = br_kind_e'(br_kind);
    assign pc_inc   = pc + PC_W'(1);
    assign br_ready = (state == ST_RUN) && !stall && !halt;
    assign accept   = br_valid && br_ready;
    assign pc_valid = (state == ST_RUN);
    assign busy     = (state == ST_RUN) || (state == ST_BRANCH);

    // A branch that cannot resolve (reserved kind, or an unwritten label) falls through as pc+1.
    always_comb begin
        tgt  = pc_inc;
        take = 1'b0;
        bad  = 1'b0;
        case (kind)
            BR_ABS: begin
                tgt  = br_target;
                take = 1'b1;
            end
            BR_LABEL: begin
                tgt  = lbl_rdata;
                take = lbl_rvalid;
                bad  = !lbl_rvalid;
            end
            BR_COND: begin
                if (br_cond) begin
                    tgt  = lbl_rdata;
                    take = lbl_rvalid;
                    bad  = !lbl_rvalid;
                end
            end
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        err_n   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !halt) begin
                    state_n = ST_RUN;
                    pc_n    = RST_VEC;
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_n = ST_HALTED;
                end else if (accept && take) begin
                    state_n = ST_BRANCH;
                    pc_n    = tgt;
                end else if (accept) begin
                    pc_n  = pc_inc;
                    err_n = bad;
                end else if (!stall) begin
                    pc_n = pc_inc;
                end
            end
            // The target is already in pc, so halting here still keeps the branch's load.
            ST_BRANCH: state_n = halt ? ST_HALTED : ST_RUN;
            ST_HALTED: begin
                if (start && !halt) state_n = ST_RUN;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            err   <= err_n;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios followed by random traffic,
// checked against a cycle-level behavioural model of the sequencing rules.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, halt, stall, lbl_we;
    logic [3:0]  lbl_waddr;
    logic [15:0] lbl_wdata;
    logic        br_valid, br_ready;
    logic [1:0]  br_kind;
    logic [15:0] br_target;
    logic [3:0]  br_label;
    logic        br_cond;
    logic [15:0] pc;
    logic        pc_valid, busy, err;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_W    (16),
        .NLBL    (16),
        .RST_VEC (16'd0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .halt      (halt),
        .stall     (stall),
        .lbl_we    (lbl_we),
        .lbl_waddr (lbl_waddr),
        .lbl_wdata (lbl_wdata),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_kind   (br_kind),
        .br_target (br_target),
        .br_label  (br_label),
        .br_cond   (br_cond),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        logic        rst_n, start, halt, stall, lbl_we;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic        br_valid;
        logic [1:0]  kind;
        logic [15:0] target;
        logic [3:0]  label;
        logic        cond;
    } stim_t;

    typedef struct { int cyc; int pc; } pc_item_t;
    typedef struct { int cyc; int pc; int busy; int ready; } stat_item_t;
    typedef enum { M_IDLE, M_RUN, M_BRANCH, M_HALTED } mstate_t;

    pc_item_t   pcq[$];
    stat_item_t statq[$];
    int         errq[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    bit         armed = 1'b0;

    mstate_t m_state = M_IDLE;
    int      m_pc = 0;
    int      m_tgt[16];
    bit      m_vld[16];
    int      def_tgt[12] = '{10, 22, 102, 152, 196, 212, 8, 39, 18, 46, 83, 60};

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic stim_t nop();
        stim_t s;
        s = '{default: 0};
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t br(input int kind, input int target, input int label, input bit cond);
        stim_t s;
        s = nop();
        s.br_valid = 1'b1;
        s.kind     = 2'(kind);
        s.target   = 16'(target);
        s.label    = 4'(label);
        s.cond     = cond;
        return s;
    endfunction

    // One clock of the reference behaviour; errq records the cycle at which err must be seen.
    task automatic modelStep(input stim_t s);
        bit ready, uses_label;
        int old_tgt;
        bit old_vld;
        ready      = (m_state == M_RUN) && !s.stall && !s.halt;
        old_tgt    = m_tgt[s.label];
        old_vld    = m_vld[s.label];
        uses_label = (s.kind == 2'd1) || (s.kind == 2'd2 && s.cond);
        if (!s.rst_n) begin
            m_state = M_IDLE;
            m_pc    = 0;
            for (int i = 0; i < 16; i++) begin
                m_tgt[i] = (i < 12) ? def_tgt[i] : 0;
                m_vld[i] = (i < 12);
            end
            return;
        end
        case (m_state)
            M_IDLE: if (s.start && !s.halt) begin m_state = M_RUN; m_pc = 0; end
            M_RUN: begin
                if (s.halt) m_state = M_HALTED;
                else if (s.br_valid && ready) begin
                    if (s.kind == 2'd3 || (uses_label && !old_vld)) begin
                        m_pc = (m_pc + 1) % 65536;
                        errq.push_back(cyc + 1);
                    end else if (s.kind == 2'd0) begin
                        m_pc = int'(s.target);
                        m_state = M_BRANCH;
                    end else if (uses_label) begin
                        m_pc = old_tgt;
                        m_state = M_BRANCH;
                    end else m_pc = (m_pc + 1) % 65536;
                end else if (!s.stall) m_pc = (m_pc + 1) % 65536;
            end
            M_BRANCH: m_state = s.halt ? M_HALTED : M_RUN;
            M_HALTED: if (s.start && !s.halt) m_state = M_RUN;
            default: m_state = M_IDLE;
        endcase
        if (s.lbl_we) begin
            m_tgt[s.waddr] = int'(s.wdata);
            m_vld[s.waddr] = 1'b1;
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        stat_item_t st;
        pc_item_t   pi;
        rst_n = s.rst_n;  start = s.start;  halt = s.halt;  stall = s.stall;
        lbl_we = s.lbl_we;  lbl_waddr = s.waddr;  lbl_wdata = s.wdata;
        br_valid = s.br_valid;  br_kind = s.kind;  br_target = s.target;
        br_label = s.label;  br_cond = s.cond;
        if (armed) begin
            st.cyc   = cyc;
            st.pc    = m_pc;
            st.busy  = (m_state == M_RUN || m_state == M_BRANCH) ? 1 : 0;
            st.ready = (m_state == M_RUN && !s.stall && !s.halt) ? 1 : 0;
            statq.push_back(st);
        end
        @(posedge clk);
        #1;
        modelStep(s);
        cyc++;
        if (armed && m_state == M_RUN) begin
            pi.cyc = cyc;
            pi.pc  = m_pc;
            pcq.push_back(pi);
        end
    endtask

    // Monitor: consumes expectations independently of the stimulus thread.
    always @(negedge clk) begin
        stat_item_t st;
        pc_item_t   pi;
        int         ec;
        if (armed) begin
            if (statq.size() > 0) begin
                st = statq.pop_front();
                checkOutput("status_cycle", cyc, st.cyc);
                checkOutput("pc", int'(pc), st.pc);
                checkOutput("busy", int'(busy), st.busy);
                checkOutput("br_ready", int'(br_ready), st.ready);
            end
            if (pc_valid) begin
                if (pcq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL pc_valid: got 1 expected 0 (cycle %0d, pc %0d)", cyc, pc);
                end else begin
                    pi = pcq.pop_front();
                    checkOutput("pc_valid_cycle", cyc, pi.cyc);
                    checkOutput("fetch_pc", int'(pc), pi.pc);
                end
            end
            if (err) begin
                if (errq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL err: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    ec = errq.pop_front();
                    checkOutput("err_cycle", cyc, ec);
                end
            end
        end
    end

    initial begin
        stim_t s;
        $display("[TB] pc_sequencer scoreboard bench starting");

        s = nop(); s.rst_n = 1'b0;
        applyStimulus(s);
        armed = 1'b1;
        applyStimulus(s);

        s = nop(); s.start = 1'b1; s.halt = 1'b1;
        applyStimulus(s);
        applyStimulus(nop());
        s = nop(); s.start = 1'b1;
        applyStimulus(s);
        repeat (3) applyStimulus(nop());
        s = br(0, 16'h1234, 0, 1'b0); s.stall = 1'b1;
        repeat (2) applyStimulus(s);
        repeat (2) applyStimulus(nop());

        applyStimulus(br(1, 0, 4, 1'b0));
        repeat (2) applyStimulus(nop());
        applyStimulus(br(2, 0, 7, 1'b0));
        s = br(2, 0, 7, 1'b1); s.lbl_we = 1'b1; s.waddr = 4'd7; s.wdata = 16'h0AAA;
        applyStimulus(s);
        applyStimulus(nop());

        applyStimulus(br(1, 0, 13, 1'b0));
        s = nop(); s.lbl_we = 1'b1; s.waddr = 4'd13; s.wdata = 16'h0300;
        applyStimulus(s);
        applyStimulus(br(1, 0, 13, 1'b0));
        applyStimulus(nop());
        applyStimulus(br(2, 0, 7, 1'b1));
        applyStimulus(nop());
        applyStimulus(br(3, 16'h5555, 1, 1'b1));

        applyStimulus(br(0, 16'hFFFE, 0, 1'b0));
        repeat (3) applyStimulus(nop());
        applyStimulus(br(1, 0, 2, 1'b0));
        s = nop(); s.halt = 1'b1;
        applyStimulus(s);
        s.start = 1'b1;
        applyStimulus(s);
        applyStimulus(nop());
        s = nop(); s.start = 1'b1;
        applyStimulus(s);
        applyStimulus(nop());
        s = br(0, 16'h0777, 0, 1'b0); s.halt = 1'b1;
        applyStimulus(s);
        s = nop(); s.start = 1'b1;
        applyStimulus(s);

        s = nop(); s.lbl_we = 1'b1; s.waddr = 4'd2; s.wdata = 16'h1234;
        applyStimulus(s);
        applyStimulus(br(1, 0, 2, 1'b0));
        s = nop(); s.rst_n = 1'b0;
        applyStimulus(s);
        repeat (3) applyStimulus(nop());
        s = nop(); s.start = 1'b1;
        applyStimulus(s);
        applyStimulus(br(1, 0, 2, 1'b0));
        applyStimulus(nop());
        applyStimulus(br(1, 0, 13, 1'b0));
        applyStimulus(br(2, 0, 7, 1'b1));
        applyStimulus(nop());

        for (int n = 0; n < 600; n++) begin
            s.rst_n    = ($urandom_range(0, 199) != 0);
            s.start    = ($urandom_range(0, 7) == 0);
            s.halt     = ($urandom_range(0, 11) == 0);
            s.stall    = ($urandom_range(0, 4) == 0);
            s.lbl_we   = ($urandom_range(0, 7) == 0);
            s.waddr    = 4'($urandom);
            s.wdata    = 16'($urandom);
            s.br_valid = ($urandom_range(0, 2) == 0);
            s.kind     = 2'($urandom);
            s.target   = ($urandom_range(0, 9) == 0) ? 16'hFFFD : 16'($urandom);
            s.label    = 4'($urandom);
            s.cond     = 1'($urandom);
            applyStimulus(s);
        end

        @(negedge clk);
        #1;
        armed = 1'b0;
        checkOutput("pc_queue_drained", pcq.size(), 0);
        checkOutput("err_queue_drained", errq.size(), 0);
        checkOutput("status_queue_drained", statq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL expose parameters: PC_W, 16, program-counter width; NLBL, 16, jump-label table depth; RST_VEC, 16'd0, PC value loaded on start.
REQ-002 SHALL expose ports (name direction width meaning):
  clk  in  1  single clock; all state updates on rising edge
  rst_n  in  1  synchronous active-low reset
  start  in  1  pulse; leaves IDLE/HALTED, loads RST_VEC
  halt  in  1  level; freezes sequencing into HALTED
  stall  in  1  level; holds PC in RUN
  lbl_we  in  1  label-table write strobe
  lbl_waddr  in  4  label entry to write
  lbl_wdata  in  16  label target address
  br_valid  in  1  branch request valid
  br_ready  out  1  branch request accepted when high with br_valid
  br_kind  in  2  00 absolute, 01 label, 10 conditional label, 11 reserved
  br_target  in  16  absolute target (kind 00)
  br_label  in  4  label index (kinds 01/10)
  br_cond  in  1  condition for kind 10
  pc  out  16  current fetch address
  pc_valid  out  1  pc is a valid fetch this cycle
  busy  out  1  state is RUN or BRANCH
  err  out  1  one-cycle pulse on bad branch
REQ-003 Clock is clk; reset is rst_n, synchronous, active-low; no other clock or reset.

Function
REQ-004 SHALL implement states IDLE, RUN, BRANCH, HALTED.
REQ-005 IDLE: pc_valid=0, br_ready=0; start -> RUN with pc=RST_VEC.
REQ-006 RUN: pc_valid=1; if stall=0 and no accepted branch, pc increments by 1 modulo 2^16 (0xFFFF -> 0x0000); stall=1 holds pc.
REQ-007 br_ready SHALL be 1 only in RUN with stall=0 and halt=0.
REQ-008 Accepted branch (br_valid&br_ready): target = br_target (00), table[br_label] (01), table[br_label] if br_cond else pc+1 (10); state -> BRANCH next cycle.
REQ-009 BRANCH: exactly one bubble cycle, pc_valid=0, pc holds resolved target; next cycle -> RUN with pc=target, pc_valid=1 (two-cycle branch latency).
REQ-010 Kind 11, or label entry with valid bit clear (kinds 01/10 when used), SHALL pulse err one cycle after acceptance and behave as not taken (pc+1, no bubble).
REQ-011 Label table: NLBL x 16-bit entries plus valid bit; lbl_we writes entry and sets valid in any state; write and lookup of same entry in same cycle returns old value.
REQ-012 halt=1 in RUN or BRANCH -> HALTED next cycle, pc frozen, pc_valid=0; halt has priority over branch and stall; a BRANCH in progress completes its pc load first.
REQ-013 HALTED: start (with halt=0) -> RUN resuming at held pc, not RST_VEC; start in IDLE with halt=1 is ignored.
REQ-014 busy = (state==RUN)|(state==BRANCH).

Reset
REQ-015 On rst_n=0 at clk edge: state=IDLE, pc=0, pc_valid=0, br_ready=0, busy=0, err=0, any pending branch discarded.
REQ-016 Reset SHALL load table defaults: entries 0..11 = 10,22,102,152,196,212,8,39,18,46,83,60 valid; 12..15 = 0 invalid.
REQ-017 Reset mid-BRANCH SHALL drop the target; no later pc_valid until start.

Structure
REQ-018 Shared package SHALL hold state enum, br_kind enum, PC_W, NLBL, default label table constant.
REQ-019 One sub-module: label_table (register file, 1 write, 1 async read, reset defaults).

Verification
REQ-020 Reset, start -> pc 0,1,2,3 on consecutive cycles, pc_valid=1; stall 2 cycles holds pc=3.
REQ-021 Kind 01 br_label=4 at pc=5 -> bubble cycle pc_valid=0, then pc=196, 197.
REQ-022 Kind 10 label=7: br_cond=0 -> pc+1 no bubble; br_cond=1 -> bubble then pc=39.
REQ-023 Kind 01 label=13 unwritten -> err pulse, pc+1; write lbl 13=0x0300, retry -> pc=0x0300.
REQ-024 pc=0xFFFF no branch -> pc=0x0000; halt during BRANCH to 102 -> HALTED with pc=102, start -> resumes 102.
REQ-025 rst_n low during BRANCH -> IDLE, pc=0, pc_valid=0; table restored to defaults.
